// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, issues SRAM-like instruction
// requests (at most one outstanding), buffers the returned word and presents
// it to IF/ID. Handles branch delay slots, flush redirects and misaligned PCs.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] flush_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_addr_error,
   output logic        if_valid,
   output logic        if_stall_req
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] pend_tgt;
   logic        pend_vld;
   logic        cancel;
   logic [31:0] inst_buf;
   logic        misal;
   logic        advance;
   logic        capture;
   logic        accepted;

   assign misal     = (pc[1:0] != 2'b00);
   assign inst_addr = pc;
   assign advance   = if_valid && !stall;
   assign accepted  = inst_req && inst_addr_ok;
   // Data lands in the buffer either from a waiting request or from a
   // request that is accepted and answered in the same cycle.
   assign capture   = (state == S_WAIT && inst_data_ok) ||
                      (state == S_REQ && accepted && inst_data_ok);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_REQ;
      else       state <= state_nxt;
   end

   // Next-state logic; flush always forces a fresh request
   always_comb begin
      state_nxt = state;
      case (state)
         S_REQ:   if (!misal && accepted) state_nxt = inst_data_ok ? S_HOLD : S_WAIT;
         S_WAIT:  if (inst_data_ok) state_nxt = S_HOLD;
         S_HOLD:  if (advance) state_nxt = S_REQ;
         default: state_nxt = S_REQ;
      endcase
      if (flush) state_nxt = S_REQ;
   end

   // Output logic; a misaligned PC completes at once as an error slot
   always_comb begin
      inst_req      = 1'b0;
      if_valid      = 1'b0;
      if_addr_error = 1'b0;
      if_inst       = 32'h0;
      if_pc         = pc;
      if (reset) begin
         if_pc = RESET_PC;
      end else begin
         case (state)
            S_REQ: begin
               if (misal) begin
                  if_valid      = 1'b1;
                  if_addr_error = 1'b1;
               end else begin
                  // a cancelled request still owes us a data beat
                  inst_req = !cancel;
               end
            end
            S_HOLD: begin
               if_valid = 1'b1;
               if_inst  = inst_buf;
            end
            default: ;
         endcase
      end
   end

   assign if_stall_req = !if_valid;

   // Next PC: flush > branch resolving now > pending branch > sequential.
   // A branch seen in the same cycle the delay slot advances is used directly.
   always_comb begin
      pc_nxt = pc;
      if (flush)             pc_nxt = flush_target;
      else if (advance) begin
         if (branch_taken)   pc_nxt = branch_target;
         else if (pend_vld)  pc_nxt = pend_tgt;
         else                pc_nxt = pc + 32'd4;
      end
   end

   // Datapath registers: PC, pending branch, cancel flag, fetch buffer
   always_ff @(posedge clk) begin
      if (reset) begin
         pc       <= RESET_PC;
         pend_vld <= 1'b0;
         pend_tgt <= 32'h0;
         cancel   <= 1'b0;
         inst_buf <= 32'h0;
      end else begin
         pc <= pc_nxt;
         if (capture) inst_buf <= inst_rdata;
         if (flush || advance) begin
            pend_vld <= 1'b0;
         end else if (branch_taken) begin
            pend_vld <= 1'b1;
            pend_tgt <= branch_target;
         end
         // an accepted request whose data has not yet returned must be dropped
         if (flush)
            cancel <= (cancel || state == S_WAIT || accepted) && !inst_data_ok;
         else if (cancel && inst_data_ok)
            cancel <= 1'b0;
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a latency-programmable instruction memory responder,
// a table of fetch records and hand sequences for flush/reset corners.
module tb_if_fetch;

   localparam logic [31:0] RPC = 32'hBFC00000;

   logic        clk = 1'b0;
   logic        reset, stall, flush, branch_taken;
   logic [31:0] flush_target, branch_target;
   logic        inst_req, inst_addr_ok, inst_data_ok;
   logic [31:0] inst_addr, inst_rdata;
   logic [31:0] if_pc, if_inst;
   logic        if_addr_error, if_valid, if_stall_req;

   if_fetch #(.RESET_PC(RPC)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .flush_target(flush_target), .branch_taken(branch_taken),
      .branch_target(branch_target), .inst_req(inst_req),
      .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .if_pc(if_pc), .if_inst(if_inst), .if_addr_error(if_addr_error),
      .if_valid(if_valid), .if_stall_req(if_stall_req)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          al;    // cycles of inst_req before addr_ok
      int          dl;    // cycles after acceptance before data_ok (0 = same)
      int          stn;   // extra stalled cycles once valid
      logic        br;    // pulse branch_taken on first cycle
      logic [31:0] btgt;
      logic [31:0] addr;  // expected fetch address
      logic        err;   // expected misaligned
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        err;
   } exp_t;

   exp_t sbq[$];
   vec_t tbl[8];
   int   checks = 0;
   int   errors = 0;

   // responder state
   int          acnt, dlat, dcnt;
   bit          mpend, force_dok;
   logic [31:0] maddr;
   logic        rst_v;

   // observed per cycle
   logic        o_req, o_aok, o_valid, o_err;
   logic [31:0] o_addr, o_pc, o_inst;

   function automatic logic [31:0] fdat(input logic [31:0] a);
      return a ^ 32'h9BC10001;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // One clock cycle: drive inputs, answer the memory protocol, sample outputs
   task automatic cyc(input logic st, input logic fl, input logic [31:0] ft,
                      input logic bt, input logic [31:0] btg);
      bit   busy;
      exp_t e;
      @(negedge clk);
      reset = rst_v; stall = st; flush = fl; flush_target = ft;
      branch_taken = bt; branch_target = btg;
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
      #1;
      busy = mpend;
      if (!reset) chk("one_outstanding", {31'b0, inst_req && busy}, 32'h0);
      if (force_dok) begin
         inst_data_ok = 1'b1; inst_rdata = 32'hDEADBEEF; force_dok = 0;
      end else if (mpend) begin
         if (dcnt == 0) begin
            inst_data_ok = 1'b1; inst_rdata = fdat(maddr); mpend = 0;
         end else dcnt--;
      end else if (inst_req && !reset) begin
         if (acnt == 0) begin
            inst_addr_ok = 1'b1; maddr = inst_addr;
            if (dlat == 0) begin
               inst_data_ok = 1'b1; inst_rdata = fdat(inst_addr);
            end else begin
               mpend = 1; dcnt = dlat - 1;
            end
         end else acnt--;
      end
      #1;
      o_req = inst_req; o_aok = inst_addr_ok; o_addr = inst_addr;
      o_valid = if_valid; o_pc = if_pc; o_inst = if_inst; o_err = if_addr_error;
      chk("stall_req", {31'b0, if_stall_req}, {31'b0, !if_valid});
      if (!reset && if_valid && !st && !fl) begin
         if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output actual_pc=%h required=none", if_pc);
         end else begin
            e = sbq.pop_front();
            chk("out_pc", if_pc, e.pc);
            chk("out_inst", if_inst, e.inst);
            chk("out_err", {31'b0, if_addr_error}, {31'b0, e.err});
         end
      end
   endtask

   // Fetch one instruction with stall held, check hold stability, then advance
   task automatic run_fetch(input vec_t v);
      int n;
      bit got;
      bit first;
      logic [31:0] ei;
      ei = v.err ? 32'h0 : fdat(v.addr);
      sbq.push_back(exp_t'{v.addr, ei, v.err});
      acnt = v.al; dlat = v.dl;
      n = 0; got = 0; first = 1;
      while (!got && n < 40) begin
         cyc(1'b1, 1'b0, 32'h0, first && v.br, v.btgt);
         first = 0; n++;
         if (o_aok) chk("req_addr", o_addr, v.addr);
         if (o_valid) got = 1;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL fetch_timeout actual=no_valid required=valid addr=%h", v.addr);
      end
      chk("valid_no_req", {31'b0, o_req}, 32'h0);
      for (int i = 0; i < v.stn; i++) begin
         cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
         chk("hold_valid", {31'b0, o_valid}, 32'h1);
         chk("hold_inst", o_inst, ei);
         chk("hold_pc", o_pc, v.addr);
         chk("hold_req", {31'b0, o_req}, 32'h0);
      end
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic chk_reset();
      chk("rst_req", {31'b0, o_req}, 32'h0);
      chk("rst_valid", {31'b0, o_valid}, 32'h0);
      chk("rst_stall_req", {31'b0, if_stall_req}, 32'h1);
      chk("rst_inst", o_inst, 32'h0);
      chk("rst_err", {31'b0, o_err}, 32'h0);
      chk("rst_pc", o_pc, RPC);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
      flush_target = 32'h0; branch_target = 32'h0;
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
      acnt = 0; dlat = 0; dcnt = 0; mpend = 0; force_dok = 0; maddr = 32'h0;
      rst_v = 1'b1;

      //            al dl stn br    btgt          addr          err
      tbl[0] = '{0, 1, 0, 1'b0, 32'h0,        32'hBFC00000, 1'b0};
      tbl[1] = '{1, 0, 3, 1'b0, 32'h0,        32'hBFC00004, 1'b0};
      tbl[2] = '{0, 2, 1, 1'b1, 32'hBFC00100, 32'hBFC00008, 1'b0};
      tbl[3] = '{0, 0, 0, 1'b0, 32'h0,        32'hBFC00100, 1'b0};
      tbl[4] = '{2, 1, 0, 1'b1, 32'hBFC00102, 32'hBFC00104, 1'b0};
      tbl[5] = '{0, 0, 2, 1'b1, 32'hFFFFFFFC, 32'hBFC00102, 1'b1};
      tbl[6] = '{0, 1, 0, 1'b0, 32'h0,        32'hFFFFFFFC, 1'b0};
      tbl[7] = '{0, 1, 0, 1'b0, 32'h0,        32'h00000000, 1'b0};

      cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_reset();
      rst_v = 1'b0;

      for (int i = 0; i < 8; i++) run_fetch(tbl[i]);

      // flush while waiting for data: stale beat dropped, then redirect
      acnt = 0; dlat = 3;
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("pre_flush_addr", o_addr, 32'h00000004);
      chk("pre_flush_aok", {31'b0, o_aok}, 32'h1);
      cyc(1'b1, 1'b1, 32'hBFC00380, 1'b0, 32'h0);
      run_fetch('{0, 1, 1, 1'b0, 32'h0, 32'hBFC00380, 1'b0});

      // flush and branch together: branch dropped
      acnt = 5;
      cyc(1'b1, 1'b1, 32'hBFC00400, 1'b1, 32'h12345678);
      run_fetch('{0, 1, 0, 1'b0, 32'h0, 32'hBFC00400, 1'b0});
      run_fetch('{1, 0, 0, 1'b0, 32'h0, 32'hBFC00404, 1'b0});

      // reset mid-wait, then a late data beat must be ignored
      acnt = 0; dlat = 4;
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("pre_rst_addr", o_addr, 32'hBFC00408);
      rst_v = 1'b1;
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_reset();
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      rst_v = 1'b0;
      mpend = 0; force_dok = 1;
      run_fetch('{1, 1, 0, 1'b0, 32'h0, RPC, 1'b0});

      chk("sb_empty", sbq.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 The block SHALL expose parameter RESET_PC, default 32'hBFC00000, meaning the first fetch address after reset.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  downstream IF/ID register holding; PC SHALL NOT advance.
REQ-006 flush  in  1  exception/eret redirect; highest priority.
REQ-007 flush_target  in  32  redirect PC for flush.
REQ-008 branch_taken  in  1  one-cycle pulse from ID: branch resolved taken.
REQ-009 branch_target  in  32  target accompanying branch_taken.
REQ-010 inst_req  out  1  instruction SRAM-like request valid.
REQ-011 inst_addr  out  32  request address (equals pc).
REQ-012 inst_addr_ok  in  1  request accepted this cycle.
REQ-013 inst_data_ok  in  1  read data returned this cycle.
REQ-014 inst_rdata  in  32  returned instruction word.
REQ-015 if_pc  out  32  PC of the instruction presented to IF/ID.
REQ-016 if_inst  out  32  instruction presented to IF/ID.
REQ-017 if_addr_error  out  1  if_pc is misaligned (pc[1:0]!=0).
REQ-018 if_valid  out  1  if_inst/if_pc/if_addr_error valid this cycle.
REQ-019 if_stall_req  out  1  equals !if_valid; fetch not complete, hazard unit SHALL stall.

Function
REQ-020 FSM states: REQ (drive inst_req), WAIT (address accepted, awaiting data), HOLD (data buffered).
REQ-021 REQ: inst_req=1 when pc[1:0]==0; on inst_addr_ok go to WAIT.
REQ-022 REQ with pc[1:0]!=0: no request; if_valid=1, if_addr_error=1, if_inst=0 in the same cycle.
REQ-023 WAIT: on inst_data_ok capture inst_rdata into the buffer and go to HOLD; at most one request outstanding.
REQ-024 HOLD: if_valid=1, if_inst=buffer, if_addr_error=0.
REQ-025 Advance condition: if_valid && !stall; on advance the PC updates and the FSM returns to REQ in the next cycle.
REQ-026 Next-PC priority: flush_target (flush) > pending branch target > pc+4, with pc+4 wrapping modulo 2^32.
REQ-027 branch_taken SHALL set a pending-branch register with branch_target; the register is consumed on the next advance (the delay slot is the instruction currently in IF) and cleared on that advance.
REQ-028 flush SHALL load pc=flush_target on the next edge regardless of stall or FSM state, clear pending-branch, and return to REQ.
REQ-029 flush in WAIT SHALL set a cancel flag; the next inst_data_ok is discarded (no capture) and clears the flag; no new inst_req until then.
REQ-030 flush and branch_taken in the same cycle: flush wins; the branch is dropped.
REQ-031 inst_addr_ok and inst_data_ok in the same cycle as the request: capture the data directly and go to HOLD.
REQ-032 stall while in REQ/WAIT does not block completion of the fetch, only the advance.

Reset
REQ-033 Reset SHALL set pc=RESET_PC, state=REQ, pending-branch=0, cancel=0, buffer=0.
REQ-034 During reset the outputs SHALL be inst_req=0, if_valid=0, if_stall_req=1, if_inst=0, if_addr_error=0, and if_pc=RESET_PC.
REQ-035 Reset mid-WAIT SHALL set cancel=0; a late inst_data_ok after reset is ignored because state is REQ.

Verification
REQ-036 Reset release, addr_ok in cycle 1, data_ok=32'h24010001 in cycle 2 -> if_valid=1, if_pc=BFC00000, then inst_addr=BFC00004.
REQ-037 HOLD with stall=1 for 3 cycles -> if_inst stable, no inst_req, pc unchanged; stall drops -> inst_addr=pc+4.
REQ-038 branch_taken target 32'hBFC00100 while the delay slot at BFC00008 is waiting -> the delay slot is delivered, then the next inst_addr=BFC00100.
REQ-039 flush target 32'hBFC00380 in WAIT -> the following data_ok is dropped, then a request to BFC00380 is issued and if_pc=BFC00380.
REQ-040 branch_target 32'hBFC00102 -> no inst_req, if_valid=1, if_addr_error=1, if_inst=0.
REQ-041 pc=32'hFFFFFFFC advance -> next pc=32'h00000000.
